lcd_bus_receiver: RTL and testbench

- Receiving end of the HD44780-style character-LCD bus (enable / rs / rw / 8-bit data) that our system drives out of the Qsys top.
- Samples the parallel bus and accepts write strobes on the falling edge of enable.
- Decodes commands and characters and maintains a 2x16 shadow of display RAM plus cursor state.
- Used as an on-chip LCD model for simulation and as a bus monitor on hardware; a read port lets a checker or VGA overlay read the shadow.

---
 rtl/lcd_bus_pkg.sv | 26 ++
 rtl/lcd_bus_capture.sv | 105 ++++++++++
 rtl/lcd_bus_receiver.sv | 192 +++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
`default_nettype none
// ============================================================================
// lcd_bus_pkg : shared opcodes, FIFO entry type and decoder states
// Rev 1.0
// ============================================================================
package lcd_bus_pkg;

    localparam logic [7:0] CLR        = 8'h01;
    localparam logic [7:0] HOME       = 8'h02;
    localparam logic [7:0] ENTRY      = 8'h04;
    localparam logic [7:0] DDRAM      = 8'h80;
    localparam logic [7:0] LINE2_BASE = 8'h40;
    localparam logic [7:0] SPACE      = 8'h20;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_bus_capture.sv
`default_nettype none
// ============================================================================
// lcd_bus_capture : bus synchronizers, enable-width qualified strobe, and
//                   captured-transaction FIFO with sticky overflow
// Rev 1.0
// ============================================================================
module lcd_bus_capture
    import lcd_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_EN_HIGH = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_rs,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    input  logic        i_pop,
    input  logic        i_err_clr,
    output logic        o_empty,
    output fifo_entry_t o_entry,
    output logic        o_ovf
);

    localparam int c_CNT_W = $clog2(MIN_EN_HIGH + 1);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_EN_MAX = c_CNT_W'(MIN_EN_HIGH);
    localparam logic [c_AW:0]      c_FULL   = (c_AW + 1)'(FIFO_DEPTH);

    // Bus bundle layout: {en, rs, rw, data[7:0]}
    logic [10:0]         r_sync [SYNC_STAGES];
    logic [10:0]         r_prev;
    logic [c_CNT_W-1:0]  r_hcnt;
    logic [10:0]         w_cur;
    logic                w_strobe;
    logic                w_push_req;
    logic                w_full;
    logic                w_do_pop;
    logic                w_do_push;
    logic                w_drop;
    fifo_entry_t         w_push_entry;

    fifo_entry_t         r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wptr;
    logic [c_AW-1:0]     r_rptr;
    logic [c_AW:0]       r_count;
    logic                r_ovf;

    assign w_cur        = r_sync[SYNC_STAGES-1];
    // A strobe needs the enable to have been seen high for the full minimum width
    assign w_strobe     = r_prev[10] & ~w_cur[10] & (r_hcnt == c_EN_MAX);
    assign w_push_req   = w_strobe & ~r_prev[8];
    assign w_push_entry = '{rs: r_prev[9], data: r_prev[7:0]};

    assign w_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = w_push_req & (~w_full | w_do_pop);
    assign w_drop    = w_push_req & w_full & ~w_do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev  <= '0;
            r_hcnt  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_sync[0] <= {i_en, i_rs, i_rw, i_data};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_cur;

            if (!w_cur[10])
                r_hcnt <= '0;
            else if (r_hcnt != c_EN_MAX)
                r_hcnt <= r_hcnt + 1'b1;

            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (i_err_clr)
                r_ovf <= 1'b0;
            else if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= w_push_entry;
    end

    assign o_empty = (r_count == '0);
    assign o_entry = r_mem[r_rptr];
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
// lcd_bus_receiver : HD44780-style bus receiver keeping a 2x16 DDRAM shadow
// Rev 1.0
// ============================================================================
module lcd_bus_receiver
    import lcd_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_EN_HIGH = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor,
    output logic       busy,
    output logic       evt_valid,
    output logic       evt_rs,
    output logic [7:0] evt_code,
    output logic       bad_cmd,
    output logic       ovf,
    input  logic       err_clr
);

    state_t      r_state;
    logic [4:0]  r_cursor;
    logic        r_inc;
    logic [4:0]  r_clr_cnt;
    logic        r_busy;
    logic        r_evt_valid;
    logic        r_evt_rs;
    logic [7:0]  r_evt_code;
    logic        r_bad;
    logic [7:0]  r_rd_data;
    logic [7:0]  r_shadow [32];

    logic        w_empty;
    fifo_entry_t w_entry;
    logic        w_pop;
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [7:0]  w_wdata;
    logic        w_bad_set;
    logic        w_go_clear;
    logic        w_cur_ld;
    logic [4:0]  w_cur_val;
    logic        w_ent_ld;

    lcd_bus_capture #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_EN_HIGH (MIN_EN_HIGH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_capture (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .i_en      (lcd_en),
        .i_rs      (lcd_rs),
        .i_rw      (lcd_rw),
        .i_data    (lcd_data),
        .i_pop     (w_pop),
        .i_err_clr (err_clr),
        .o_empty   (w_empty),
        .o_entry   (w_entry),
        .o_ovf     (ovf)
    );

    assign w_pop = (r_state == ST_IDLE) & ~w_empty;

    // Command decode: the highest set bit of the opcode selects the command
    always_comb begin
        w_bad_set  = 1'b0;
        w_go_clear = 1'b0;
        w_cur_ld   = 1'b0;
        w_cur_val  = r_cursor;
        w_ent_ld   = 1'b0;
        if (w_pop && !w_entry.rs) begin
            if ((w_entry.data & DDRAM) != 8'h00) begin
                if (w_entry.data[6:4] == 3'b000) begin
                    w_cur_ld  = 1'b1;
                    w_cur_val = {1'b0, w_entry.data[3:0]};
                end else if (w_entry.data[6:4] == LINE2_BASE[6:4]) begin
                    w_cur_ld  = 1'b1;
                    w_cur_val = {1'b1, w_entry.data[3:0]};
                end else begin
                    w_bad_set = 1'b1;
                end
            end else if (w_entry.data[6]) begin
                w_bad_set = 1'b1;
            end else if (w_entry.data[5:3] != 3'b000) begin
                w_bad_set = 1'b0;
            end else if ((w_entry.data & ENTRY) != 8'h00) begin
                w_ent_ld = 1'b1;
            end else if ((w_entry.data & HOME) != 8'h00) begin
                w_cur_ld  = 1'b1;
                w_cur_val = 5'd0;
            end else if ((w_entry.data & CLR) != 8'h00) begin
                w_go_clear = 1'b1;
            end else begin
                w_bad_set = 1'b1;
            end
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cursor;
        w_wdata = w_entry.data;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = SPACE;
        end else if (w_pop && w_entry.rs) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= ST_IDLE;
            r_cursor    <= 5'd0;
            r_inc       <= 1'b1;
            r_clr_cnt   <= 5'd0;
            r_busy      <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_rs    <= 1'b0;
            r_evt_code  <= 8'h00;
            r_bad       <= 1'b0;
            r_rd_data   <= 8'h00;
        end else begin
            r_rd_data   <= r_shadow[rd_addr];
            r_evt_valid <= w_pop;
            if (w_pop) begin
                r_evt_rs   <= w_entry.rs;
                r_evt_code <= w_entry.data;
            end

            if (err_clr)
                r_bad <= 1'b0;
            else if (w_bad_set)
                r_bad <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        if (w_entry.rs) begin
                            r_cursor <= r_inc ? r_cursor + 5'd1 : r_cursor - 5'd1;
                        end else begin
                            if (w_cur_ld) r_cursor <= w_cur_val;
                            if (w_ent_ld) r_inc    <= w_entry.data[1];
                            if (w_go_clear) begin
                                r_cursor  <= 5'd0;
                                r_inc     <= 1'b1;
                                r_clr_cnt <= 5'd0;
                                r_busy    <= 1'b1;
                                r_state   <= ST_CLEAR;
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 5'd1;
                    if (r_clr_cnt == 5'd31) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read-before-write on a same-address collision falls out of the NBA ordering
    always_ff @(posedge clk_clk) begin
        if (w_we) r_shadow[w_waddr] <= w_wdata;
    end

    assign rd_data   = r_rd_data;
    assign cursor    = r_cursor;
    assign busy      = r_busy;
    assign evt_valid = r_evt_valid;
    assign evt_rs    = r_evt_rs;
    assign evt_code  = r_evt_code;
    assign bad_cmd   = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// ============================================================================
// tb_lcd_bus_receiver : scoreboard bench for the LCD bus receiver
// Rev 1.0
// ============================================================================
module tb_lcd_bus_receiver;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       busy, evt_valid, evt_rs, bad_cmd, ovf, err_clr;
    logic [7:0] evt_code;

    int n_cmp = 0;
    int n_err = 0;
    int n_evt = 0;
    int busy_run = 0;
    int busy_len = 0;
    logic [8:0] sb [$];

    always #5 clk_clk = ~clk_clk;

    lcd_bus_receiver #(
        .SYNC_STAGES (2),
        .MIN_EN_HIGH (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .lcd_en        (lcd_en),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_data      (lcd_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .cursor        (cursor),
        .busy          (busy),
        .evt_valid     (evt_valid),
        .evt_rs        (evt_rs),
        .evt_code      (evt_code),
        .bad_cmd       (bad_cmd),
        .ovf           (ovf),
        .err_clr       (err_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor and busy-width measurement
    always @(negedge clk_clk) begin : mon
        logic [8:0] exp_v;
        if (reset_reset_n) begin
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                busy_len = busy_run;
                busy_run = 0;
            end
            if (evt_valid) begin
                n_evt++;
                check_val("evt_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    check_val("evt_rs_code", {23'd0, evt_rs, evt_code}, {23'd0, exp_v});
                end
            end
        end
    end

    task automatic lcd_write(input logic rs, input logic [7:0] d, input logic rw,
                             input int hi, input int lo, input bit expect_evt);
        if (expect_evt) sb.push_back({rs, d});
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_en   = 1'b1;
        repeat (hi) @(negedge clk_clk);
        lcd_en = 1'b0;
        repeat (lo) @(negedge clk_clk);
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        lcd_write(rs, d, 1'b0, 6, 4, 1'b1);
    endtask

    task automatic wait_quiet(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk_clk);
        end
        check_val(tag, 32'(sb.size() == 0 && !busy), 32'd1);
        repeat (3) @(negedge clk_clk);
    endtask

    task automatic rd_shadow(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        @(negedge clk_clk);
        d = rd_data;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        @(negedge clk_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int ev0;
        reset_reset_n = 1'b0;
        lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
        rd_addr = 5'd0; err_clr = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        check_val("rst_rd_data",   32'(rd_data),   32'h0);
        check_val("rst_cursor",    32'(cursor),    32'h0);
        check_val("rst_busy",      32'(busy),      32'h0);
        check_val("rst_evt_valid", 32'(evt_valid), 32'h0);
        check_val("rst_evt_rs",    32'(evt_rs),    32'h0);
        check_val("rst_evt_code",  32'(evt_code),  32'h0);
        check_val("rst_bad_cmd",   32'(bad_cmd),   32'h0);
        check_val("rst_ovf",       32'(ovf),       32'h0);

        // Clear fills the shadow with spaces
        send(1'b0, 8'h01);
        wait_quiet("clr_done");
        check_val("clr_busy_len", 32'(busy_len), 32'd32);
        for (int a = 0; a < 32; a++) begin
            rd_shadow(5'(a), d);
            check_val($sformatf("clr_shadow_%0d", a), 32'(d), 32'h20);
        end
        check_val("clr_cursor", 32'(cursor), 32'd0);

        // Characters with auto-increment
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        wait_quiet("ab_done");
        rd_shadow(5'd0, d); check_val("ab_shadow0", 32'(d), 32'h41);
        rd_shadow(5'd1, d); check_val("ab_shadow1", 32'(d), 32'h42);
        check_val("ab_cursor", 32'(cursor), 32'd2);

        // Line 2 addressing, bad DDRAM address, error clear
        send(1'b0, 8'hC5);
        wait_quiet("l2_addr_done");
        check_val("l2_cursor_set", 32'(cursor), 32'd21);
        send(1'b1, 8'h5A);
        wait_quiet("l2_char_done");
        rd_shadow(5'd21, d); check_val("l2_shadow21", 32'(d), 32'h5A);
        check_val("l2_cursor", 32'(cursor), 32'd22);
        send(1'b0, 8'h90);
        wait_quiet("bad_done");
        check_val("bad_set", 32'(bad_cmd), 32'd1);
        check_val("bad_cursor", 32'(cursor), 32'd22);
        pulse_err_clr();
        check_val("bad_cleared", 32'(bad_cmd), 32'd0);

        // Decrement mode wraps 0 -> 31
        send(1'b0, 8'h04);
        send(1'b0, 8'h80);
        send(1'b1, 8'h58);
        wait_quiet("dec_done");
        rd_shadow(5'd0, d); check_val("dec_shadow0", 32'(d), 32'h58);
        check_val("dec_cursor_wrap", 32'(cursor), 32'd31);

        // Short pulse and read strobe are both ignored
        ev0 = n_evt;
        lcd_write(1'b1, 8'h55, 1'b0, 2, 4, 1'b0);
        lcd_write(1'b1, 8'h66, 1'b1, 6, 4, 1'b0);
        repeat (10) @(negedge clk_clk);
        check_val("ignored_evt_count", 32'(n_evt), 32'(ev0));
        check_val("ignored_cursor", 32'(cursor), 32'd31);
        rd_shadow(5'd31, d); check_val("ignored_shadow31", 32'(d), 32'h20);

        // Burst during clear: four queued, two dropped
        check_val("pre_burst_ovf", 32'(ovf), 32'd0);
        lcd_write(1'b0, 8'h01, 1'b0, 4, 1, 1'b1);
        for (int j = 0; j < 6; j++)
            lcd_write(1'b1, 8'h61 + 8'(j), 1'b0, 4, 1, j < 4);
        check_val("burst_busy_still", 32'(busy), 32'd1);
        wait_quiet("burst_done");
        check_val("burst_ovf", 32'(ovf), 32'd1);
        check_val("burst_busy_len", 32'(busy_len), 32'd32);
        for (int a = 0; a < 4; a++) begin
            rd_shadow(5'(a), d);
            check_val($sformatf("burst_shadow_%0d", a), 32'(d), 32'(8'h61 + 8'(a)));
        end
        rd_shadow(5'd4, d); check_val("burst_shadow_4", 32'(d), 32'h20);
        check_val("burst_cursor", 32'(cursor), 32'd4);
        pulse_err_clr();
        check_val("ovf_cleared", 32'(ovf), 32'd0);

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
